// File: rtl/program_loader_if.sv
// Byte-stream and program-memory write bus of the program loader.
// The slave side is the loader itself; the master side is whatever feeds it
// the stream and watches the memory writes.
interface program_loader_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  start_i;
    logic [7:0]            byte_data_i;
    logic                  byte_valid_i;
    logic                  byte_ready_o;
    logic                  mem_we_o;
    logic [DATA_WIDTH-1:0] mem_address_o;
    logic [DATA_WIDTH-1:0] mem_data_o;
    logic                  cpu_reset_o;
    logic                  busy_o;
    logic                  done_o;
    logic                  error_o;
    logic [15:0]           words_loaded_o;

    modport master (
        output start_i, byte_data_i, byte_valid_i,
        input  byte_ready_o, mem_we_o, mem_address_o, mem_data_o,
        input  cpu_reset_o, busy_o, done_o, error_o, words_loaded_o
    );

    modport slave (
        input  start_i, byte_data_i, byte_valid_i,
        output byte_ready_o, mem_we_o, mem_address_o, mem_data_o,
        output cpu_reset_o, busy_o, done_o, error_o, words_loaded_o
    );
endinterface

// File: rtl/program_loader.sv
// Program loader: takes a byte stream of the form
//   word count (2 bytes, MSB first), then that many 32-bit words (MSB first)
// and writes each word into program memory starting at BASE_ADDRESS, while
// holding the processor in reset so it boots from the fresh image.
module program_loader #(
    parameter int                    MEMORY_DEPTH = 32,
    parameter int                    DATA_WIDTH   = 32,
    parameter logic [DATA_WIDTH-1:0] BASE_ADDRESS = 32'h0040_0000
) (
    input logic             clk,
    input logic             reset,
    program_loader_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERROR
    } state_t;

    localparam logic [15:0] DEPTH_LIMIT = 16'(MEMORY_DEPTH);

    state_t                state;
    state_t                next_state;
    logic                  transfer;
    logic                  load_start;
    logic [15:0]           length;
    logic [7:0]            length_hi;
    logic [15:0]           word_count;
    logic [DATA_WIDTH-9:0] partial_word;
    logic [1:0]            byte_index;
    logic [DATA_WIDTH-1:0] word_offset;

    assign word_offset = {{(DATA_WIDTH-18){1'b0}}, bus.words_loaded_o, 2'b00};

    // State register; a reset anywhere in a load drops straight back to idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state decode: handshake, length range check and word completion.
    always_comb begin
        next_state = state;
        transfer   = bus.byte_valid_i && bus.byte_ready_o;
        load_start = 1'b0;
        length     = {length_hi, bus.byte_data_i};
        case (state)
            S_IDLE, S_DONE, S_ERROR: begin
                if (bus.start_i) begin
                    next_state = S_LEN_HI;
                    load_start = 1'b1;
                end
            end
            S_LEN_HI: begin
                if (transfer) begin
                    next_state = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (transfer) begin
                    if (length == 16'd0) begin
                        next_state = S_DONE;
                    end else if (length > DEPTH_LIMIT) begin
                        next_state = S_ERROR;
                    end else begin
                        next_state = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (transfer && byte_index == 2'd3) begin
                    next_state = S_WRITE;
                end
            end
            S_WRITE: begin
                if (bus.words_loaded_o + 16'd1 == word_count) begin
                    next_state = S_DONE;
                end else begin
                    next_state = S_DATA;
                end
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Datapath and registered status outputs, all decoded from the next state
    // so they line up with the state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.byte_ready_o   <= 1'b0;
            bus.mem_we_o       <= 1'b0;
            bus.mem_address_o  <= '0;
            bus.mem_data_o     <= '0;
            bus.cpu_reset_o    <= 1'b0;
            bus.busy_o         <= 1'b0;
            bus.done_o         <= 1'b0;
            bus.error_o        <= 1'b0;
            bus.words_loaded_o <= 16'd0;
            length_hi          <= 8'd0;
            word_count         <= 16'd0;
            partial_word       <= '0;
            byte_index         <= 2'd0;
        end else begin
            bus.mem_we_o     <= 1'b0;
            bus.byte_ready_o <= (next_state == S_LEN_HI) || (next_state == S_LEN_LO) ||
                                (next_state == S_DATA);
            bus.busy_o       <= (next_state == S_LEN_HI) || (next_state == S_LEN_LO) ||
                                (next_state == S_DATA)   || (next_state == S_WRITE);
            bus.cpu_reset_o  <= (next_state == S_LEN_HI) || (next_state == S_LEN_LO) ||
                                (next_state == S_DATA)   || (next_state == S_WRITE);
            bus.done_o       <= (next_state == S_DONE);
            bus.error_o      <= (next_state == S_ERROR);

            if (load_start) begin
                bus.words_loaded_o <= 16'd0;
                byte_index         <= 2'd0;
            end

            if (state == S_LEN_HI && transfer) begin
                length_hi <= bus.byte_data_i;
            end

            if (state == S_LEN_LO && transfer) begin
                word_count <= length;
            end

            if (state == S_DATA && transfer) begin
                partial_word <= {partial_word[DATA_WIDTH-17:0], bus.byte_data_i};
                byte_index   <= byte_index + 2'd1;
                if (byte_index == 2'd3) begin
                    bus.mem_we_o      <= 1'b1;
                    bus.mem_data_o    <= {partial_word, bus.byte_data_i};
                    bus.mem_address_o <= BASE_ADDRESS + word_offset;
                end
            end

            if (state == S_WRITE) begin
                bus.words_loaded_o <= bus.words_loaded_o + 16'd1;
                byte_index         <= 2'd0;
            end
        end
    end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Writer-side counterpart of the program ROM: receives a byte stream (e.g. from a serial receiver) and writes 32-bit instruction words into a writable program memory.
- While loading, it holds the MIPS core in reset so the processor starts from a freshly loaded image.
- Stream format: 16-bit word count N (MSB byte first), then N words, each sent MSB byte first (same word order as text.dat hex).

Parameters:
- MEMORY_DEPTH, 32, number of words in program memory; N > MEMORY_DEPTH is an error.
- DATA_WIDTH, 32, instruction/address width; fixed at 32 (4 bytes per word).
- BASE_ADDRESS, 32'h0040_0000, byte address of word 0 (text segment base).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- start_i  input  1  one-cycle pulse; begins a load when idle or done.
- byte_data_i  input  8  incoming stream byte.
- byte_valid_i  input  1  byte_data_i valid.
- byte_ready_o  output  1  loader can accept a byte this cycle.
- mem_we_o  output  1  program memory write enable (one-cycle pulse per word).
- mem_address_o  output  DATA_WIDTH  byte address of word being written.
- mem_data_o  output  DATA_WIDTH  assembled instruction word.
- cpu_reset_o  output  1  holds the core in reset during a load.
- busy_o  output  1  load in progress.
- done_o  output  1  sticky, load completed without error.
- error_o  output  1  sticky, word count out of range.
- words_loaded_o  output  16  count of words written in current/last load.

Behaviour:
- Reset: state IDLE; byte_ready_o=0, mem_we_o=0, mem_address_o=0, mem_data_o=0, cpu_reset_o=0, busy_o=0, done_o=0, error_o=0, words_loaded_o=0. Reset mid-load aborts immediately. Words already written stay in memory.
- Byte transfer occurs on a rising edge where byte_valid_i && byte_ready_o. byte_ready_o is a registered state decode: high in LEN_HI, LEN_LO, DATA, and low otherwise.
- States:
  - IDLE: start_i -> LEN_HI. Clear done_o, error_o, words_loaded_o, byte index. Set busy_o=1 and cpu_reset_o=1.
  - LEN_HI: on transfer, N[15:8] <= byte; go to LEN_LO.
  - LEN_LO: on transfer, N[7:0] <= byte. Then:
    - if N==0 -> DONE;
    - else if N > MEMORY_DEPTH -> ERROR;
    - else -> DATA.
  - DATA: on transfer, shift the byte into the word register (first byte lands in [31:24]) and increment the byte index 0..3. On the 4th byte -> WRITE.
  - WRITE: exactly one cycle.
    - mem_we_o=1, mem_data_o=word, mem_address_o=BASE_ADDRESS + 4*words_loaded_o (value before increment).
    - words_loaded_o increments at the end of this cycle; byte index resets to 0.
    - If words_loaded_o+1 == N -> DONE, else -> DATA.
  - DONE: busy_o=0, cpu_reset_o=0, done_o=1 (held). start_i restarts via the IDLE actions.
  - ERROR: busy_o=0, cpu_reset_o=0, error_o=1 (held), no writes issued. start_i restarts.
- Latency: the 4th data byte accepted at edge k produces mem_we_o high in the cycle after edge k+... (i.e. the cycle following the accept), for exactly one cycle. Maximum throughput is 1 word per 5 cycles.
- mem_address_o and mem_data_o hold their last value when mem_we_o=0. Memory samples only when mem_we_o=1.
- start_i while busy is ignored.
- byte_valid_i with ready low: the byte is not consumed, and the source must hold it.
- Address arithmetic is modulo 2^DATA_WIDTH. No overflow check is needed, because N ≤ MEMORY_DEPTH.
- No timeout: a stalled stream leaves the block in LEN_*/DATA with cpu_reset_o=1 until reset.

Test Plan:
- Reset, then idle 5 cycles -> all outputs 0, byte_ready_o=0.
- start_i, stream 00 02 | 20 08 00 05 | 01 09 50 20 with valid always high ->
  - write 1: mem_we_o pulses with 0x0040_0000/0x2008_0005;
  - write 2: mem_we_o pulses with 0x0040_0004/0x0109_5020;
  - then done_o=1, cpu_reset_o=0, words_loaded_o=2.
- Same stream with byte_valid_i toggling every other cycle -> identical write sequence, each byte accepted only when valid&&ready, no duplicates.
- Count 00 00 -> DONE right after LEN_LO, no mem_we_o, done_o=1. Count 00 21 with MEMORY_DEPTH=32 -> error_o=1, done_o=0, no writes, byte_ready_o=0.
- Assert reset after 2 data bytes of word 0 -> all outputs return to reset values next cycle, no write. A new start_i plus full stream then loads correctly.
- start_i pulsed during DATA -> ignored. start_i in DONE -> done_o clears, busy_o=1, second image overwrites from 0x0040_0000.
